aes_key_expand_seq: RTL and testbench

//  Sequential AES key schedule for 128/192/256-bit keys, selected at run time. Produces one
//  32-bit schedule word per clock through a single shared 4-byte S-box path, then stores the

---
 rtl/aes_key_expand_seq_if.sv | 28 ++
 rtl/aes_key_expand_seq.sv | 238 +++++++++++++++++++++++
 tb/tb_aes_key_expand_seq.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expand_seq_if.sv
// Bus bundle for aes_key_expand_seq: start/length/key request side, status
// flags, and the round-key read port. clk and rst_n stay plain module ports.
interface aes_key_expand_seq_if #(
    parameter int MAX_NK = 8,
    parameter int IDX_W  = 4
);
    logic                    start;
    logic [1:0]              key_len;
    logic [32*MAX_NK-1:0]    key;
    logic                    busy;
    logic                    done;
    logic                    keys_valid;
    logic                    len_err;
    logic [IDX_W-1:0]        rk_idx;
    logic [127:0]            rk_out;

    // Requester side: issues expansion requests and reads round keys.
    modport master (
        output start, key_len, key, rk_idx,
        input  busy, done, keys_valid, len_err, rk_out
    );

    // Key expander side.
    modport slave (
        input  start, key_len, key, rk_idx,
        output busy, done, keys_valid, len_err, rk_out
    );
endinterface

// File: rtl/aes_key_expand_seq.sv
// Sequential AES key schedule (128/192/256-bit keys chosen at run time).
// One 32-bit schedule word is produced per clock through a single shared
// SubWord (4 S-boxes); the full schedule is kept in a word array and read
// back as registered 128-bit round keys.
//
// Optional feature macro: AES_KEYEXP_REVERSE_READ_EN
//   defined   - rk_idx is mapped to Nr-rk_idx before lookup (decrypt order).
//   undefined - direct indexing.
module aes_key_expand_seq #(
    parameter int MAX_NK = 8,
    parameter int MAX_NR = 14,
    parameter int IDX_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_key_expand_seq_if.slave  bus
);

    localparam int NUM_WORDS = 4 * (MAX_NR + 1);
    localparam int W_IDX_W   = $clog2(NUM_WORDS);
    localparam int NK_W      = $clog2(MAX_NK + 1);
    localparam int KW_IDX_W  = $clog2(MAX_NK);

    // AES S-box, entry b at bits [8*(255-b) +: 8] (entry 0 in the MSB byte).
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXPAND,
        ST_DONE
    } state_e;

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]),
                sub_byte(w[15:8]),  sub_byte(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_e              state_q, state_d;
    logic [NK_W-1:0]     nk_q, nk_d;          // key length in words (4/6/8)
    logic [IDX_W-1:0]    nr_q, nr_d;          // number of rounds (10/12/14)
    logic [W_IDX_W-1:0]  i_q, i_d;            // index of the word being generated
    logic [NK_W-1:0]     mod_q, mod_d;        // i % Nk, kept as a wrapping counter
    logic [7:0]          rcon_q, rcon_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                keys_valid_q, keys_valid_d;
    logic                len_err_q, len_err_d;
    logic [127:0]        rk_out_q, rk_out_d;

    logic [31:0]         w_mem [NUM_WORDS];
    logic [31:0]         key_word [MAX_NK];   // key_word[0] = w0 = key MSB word

    logic [W_IDX_W-1:0]  last_word;
    logic [31:0]         prev_word;
    logic [31:0]         back_word;
    logic [31:0]         sbox_in;
    logic [31:0]         sbox_out;
    logic [31:0]         temp_word;
    logic [31:0]         new_word;
    logic [IDX_W-1:0]    rd_idx;

    for (genvar g = 0; g < MAX_NK; g++) begin : g_key_word
        assign key_word[g] = bus.key[32*(MAX_NK-g)-1 -: 32];
    end

    // Index of the final schedule word, 4*(Nr+1)-1.
    assign last_word = W_IDX_W'({nr_q, 2'b11});

    // Next schedule word: w[i] = w[i-Nk] ^ temp through the one shared SubWord.
    always_comb begin
        prev_word = w_mem[i_q - W_IDX_W'(1)];
        back_word = w_mem[i_q - W_IDX_W'(nk_q)];
        sbox_in   = (mod_q == '0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        sbox_out  = sub_word(sbox_in);
        if (mod_q == '0) begin
            temp_word = sbox_out ^ {rcon_q, 24'h0};
        end else if (nk_q == NK_W'(8) && mod_q == NK_W'(4)) begin
            temp_word = sbox_out;
        end else begin
            temp_word = prev_word;
        end
        new_word = back_word ^ temp_word;
    end

    // FSM next-state and control/status next values.
    always_comb begin
        // NOTE: every signal gets its hold/default value first so no path
        // through the case leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        nk_d         = nk_q;
        nr_d         = nr_q;
        i_d          = i_q;
        mod_d        = mod_q;
        rcon_d       = rcon_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        keys_valid_d = keys_valid_q;
        len_err_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    if (bus.key_len == 2'b11) begin
                        len_err_d = 1'b1;
                    end else begin
                        case (bus.key_len)
                            2'b00:   begin nk_d = NK_W'(4); nr_d = IDX_W'(10); end
                            2'b01:   begin nk_d = NK_W'(6); nr_d = IDX_W'(12); end
                            default: begin nk_d = NK_W'(8); nr_d = IDX_W'(14); end
                        endcase
                        state_d      = ST_LOAD;
                        busy_d       = 1'b1;
                        keys_valid_d = 1'b0;
                    end
                end
            end
            ST_LOAD: begin
                i_d     = W_IDX_W'(nk_q);
                mod_d   = '0;
                rcon_d  = 8'h01;
                state_d = ST_EXPAND;
            end
            ST_EXPAND: begin
                i_d   = i_q + W_IDX_W'(1);
                mod_d = (mod_q == nk_q - NK_W'(1)) ? '0 : mod_q + NK_W'(1);
                if (mod_q == '0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q == last_word) begin
                    state_d      = ST_DONE;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    keys_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Round-key lookup; indices beyond the latched Nr read as zero.
    always_comb begin
`ifdef AES_KEYEXP_REVERSE_READ_EN
        rd_idx = nr_q - bus.rk_idx;
`else
        rd_idx = bus.rk_idx;
`endif
        if (bus.rk_idx > nr_q) begin
            rk_out_d = '0;
        end else begin
            rk_out_d = {w_mem[W_IDX_W'({rd_idx, 2'b00})],
                        w_mem[W_IDX_W'({rd_idx, 2'b01})],
                        w_mem[W_IDX_W'({rd_idx, 2'b10})],
                        w_mem[W_IDX_W'({rd_idx, 2'b11})]};
        end
    end

    // State, control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            nk_q         <= NK_W'(4);
            nr_q         <= '0;
            i_q          <= '0;
            mod_q        <= '0;
            rcon_q       <= 8'h01;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            len_err_q    <= 1'b0;
            rk_out_q     <= '0;
        end else begin
            state_q      <= state_d;
            nk_q         <= nk_d;
            nr_q         <= nr_d;
            i_q          <= i_d;
            mod_q        <= mod_d;
            rcon_q       <= rcon_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            keys_valid_q <= keys_valid_d;
            len_err_q    <= len_err_d;
            rk_out_q     <= rk_out_d;
        end
    end

    // Schedule storage: key words in LOAD, one generated word per EXPAND cycle.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; keys_valid tells
        // the consumer when its contents are meaningful.
        if (state_q == ST_LOAD) begin
            for (int j = 0; j < MAX_NK; j++) begin
                if (NK_W'(j) < nk_q) begin
                    w_mem[W_IDX_W'(j)] <= key_word[KW_IDX_W'(j)];
                end
            end
        end else if (state_q == ST_EXPAND) begin
            w_mem[i_q] <= new_word;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.keys_valid = keys_valid_q;
    assign bus.len_err    = len_err_q;
    assign bus.rk_out     = rk_out_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench for aes_key_expand_seq: known-answer vector table,
// hand-written corner sequences, and random keys against a FIPS-197 style
// reference model whose S-box is derived from GF(2^8) arithmetic.
module tb_aes_key_expand_seq;
    localparam int MAX_NK = 8;
    localparam int MAX_NR = 14;
    localparam int IDX_W  = 4;

    typedef struct {
        logic [1:0]   len;
        logic [255:0] key;
        int           idx;
        logic [127:0] exp;
        logic [127:0] mask;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_key_expand_seq_if #(.MAX_NK(MAX_NK), .IDX_W(IDX_W)) bus ();

    aes_key_expand_seq #(.MAX_NK(MAX_NK), .MAX_NR(MAX_NR), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cur_nr   = 0;

    logic [7:0]  sbox_m [$];
    logic [7:0]  rcon_m [$];
    logic [31:0] w_m    [$];
    vec_t        vecs   [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    task automatic build_tables();
        logic [7:0] x;
        logic [7:0] inv;
        sbox_m.delete();
        for (int b = 0; b < 256; b++) begin
            x   = 8'(b);
            inv = 8'h00;
            if (b != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, x);
            end
            sbox_m.push_back(inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                             ^ rotl8(inv, 4) ^ 8'h63);
        end
        rcon_m.delete();
        rcon_m.push_back(8'h00);
        rcon_m.push_back(8'h01);
        for (int j = 2; j <= 10; j++) rcon_m.push_back(gmul(rcon_m[j-1], 8'h02));
    endtask

    function automatic logic [31:0] sub_word_m(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic model_expand(input logic [1:0] len, input logic [255:0] key);
        int nk;
        int nr;
        logic [31:0]  t;
        logic [255:0] kk;
        nk = 4 + 2 * int'(len);
        nr = nk + 6;
        kk = key;
        w_m.delete();
        for (int i = 0; i < nk; i++) begin
            w_m.push_back(kk[255:224]);
            kk = kk << 32;
        end
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w_m[i-1];
            if (i % nk == 0)
                t = sub_word_m({t[23:0], t[31:24]}) ^ {rcon_m[i / nk], 24'h0};
            else if (nk == 8 && i % nk == 4)
                t = sub_word_m(t);
            w_m.push_back(w_m[i-nk] ^ t);
        end
    endtask

    // Reads logical round key t (inverse order is undone when the reverse
    // read feature is built in, so expectations are written in forward order).
    task automatic read_rk(input int t, output logic [127:0] rk);
        int a;
`ifdef AES_KEYEXP_REVERSE_READ_EN
        a = (t <= cur_nr) ? cur_nr - t : t;
`else
        a = t;
`endif
        bus.rk_idx = IDX_W'(a);
        @(negedge clk);
        rk = bus.rk_out;
    endtask

    task automatic run_expand(input logic [1:0] len, input logic [255:0] key,
                              input int poke_at, input string tag);
        int nk;
        int nr;
        int lat;
        int exp_lat;
        nk      = 4 + 2 * int'(len);
        nr      = nk + 6;
        exp_lat = 1 + 4 * (nr + 1) - nk;
        bus.key_len = len;
        bus.key     = key;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        check({tag, " busy_after_start"}, 128'(bus.busy), 128'(1));
        check({tag, " kv_cleared"}, 128'(bus.keys_valid), 128'(0));
        while (bus.done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == poke_at) begin
                bus.start   = 1'b1;
                bus.key_len = 2'b10;
                bus.key     = ~key;
            end else begin
                bus.start = 1'b0;
            end
        end
        check({tag, " latency"}, 128'(lat), 128'(exp_lat));
        check({tag, " busy_at_done"}, 128'(bus.busy), 128'(0));
        check({tag, " kv_at_done"}, 128'(bus.keys_valid), 128'(1));
        @(negedge clk);
        check({tag, " done_pulse"}, 128'(bus.done), 128'(0));
        check({tag, " kv_hold"}, 128'(bus.keys_valid), 128'(1));
        cur_nr = nr;
    endtask

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FULL = {128{1'b1}};
    localparam logic [127:0] W3   = {96'h0, 32'hffffffff};

    initial begin
        logic [127:0] pad128;
        logic [63:0]  pad64;
        logic [255:0] k128p;
        logic [255:0] k192p;
        logic [255:0] rkey;
        logic [127:0] rk;
        logic [1:0]   prev_len;
        logic [255:0] prev_key;
        logic         have_prev;
        logic [1:0]   rlen;

        bus.start   = 1'b0;
        bus.key_len = 2'b00;
        bus.key     = '0;
        bus.rk_idx  = '0;
        build_tables();

        pad128 = {$urandom, $urandom, $urandom, $urandom};
        pad64  = {$urandom, $urandom};
        k128p  = {K128, pad128};
        k192p  = {K192, pad64};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst busy", 128'(bus.busy), 128'(0));
        check("rst done", 128'(bus.done), 128'(0));
        check("rst keys_valid", 128'(bus.keys_valid), 128'(0));
        check("rst len_err", 128'(bus.len_err), 128'(0));
        check("rst rk_out", bus.rk_out, 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Known-answer table.
        vecs.push_back('{2'b00, k128p, 0,  K128, FULL});
        vecs.push_back('{2'b00, k128p, 1,  128'ha0fafe1788542cb123a339392a6c7605, FULL});
        vecs.push_back('{2'b00, k128p, 10, RK10_128, FULL});
        vecs.push_back('{2'b00, k128p, 11, 128'h0, FULL});
        vecs.push_back('{2'b01, k192p, 12, {96'h0, 32'h01002202}, W3});
        vecs.push_back('{2'b01, k192p, 13, 128'h0, FULL});
        vecs.push_back('{2'b01, k192p, 0,  K192[191:64], FULL});
        vecs.push_back('{2'b10, K256,  14, {96'h0, 32'h706c631e}, W3});
        vecs.push_back('{2'b10, K256,  15, 128'h0, FULL});
        vecs.push_back('{2'b10, K256,  0,  K256[255:128], FULL});

        have_prev = 1'b0;
        prev_len  = 2'b00;
        prev_key  = '0;
        for (int k = 0; k < vecs.size(); k++) begin
            if (!have_prev || vecs[k].len != prev_len || vecs[k].key != prev_key) begin
                run_expand(vecs[k].len, vecs[k].key, -1, $sformatf("vec%0d", k));
                have_prev = 1'b1;
                prev_len  = vecs[k].len;
                prev_key  = vecs[k].key;
            end
            read_rk(vecs[k].idx, rk);
            check($sformatf("vec%0d rk%0d", k, vecs[k].idx), rk & vecs[k].mask,
                  vecs[k].exp & vecs[k].mask);
        end

        // start (with a different key/length) while busy is ignored.
        run_expand(2'b00, k128p, 10, "ignore");
        read_rk(10, rk);
        check("ignore rk10", rk, RK10_128);
        read_rk(0, rk);
        check("ignore rk0", rk, K128);

        // Illegal length from DONE: len_err pulse, schedule stays valid.
        bus.key_len = 2'b11;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("lenerr pulse", 128'(bus.len_err), 128'(1));
        check("lenerr kv", 128'(bus.keys_valid), 128'(1));
        check("lenerr busy", 128'(bus.busy), 128'(0));
        @(negedge clk);
        check("lenerr end", 128'(bus.len_err), 128'(0));
        check("lenerr busy2", 128'(bus.busy), 128'(0));
        read_rk(10, rk);
        check("lenerr rk10", rk, RK10_128);

        // Asynchronous reset during an AES-256 expansion.
        bus.key_len = 2'b10;
        bus.key     = K256;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        check("abort busy_before", 128'(bus.busy), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", 128'(bus.busy), 128'(0));
        check("abort kv", 128'(bus.keys_valid), 128'(0));
        check("abort done", 128'(bus.done), 128'(0));
        check("abort rk_out", bus.rk_out, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort idle busy", 128'(bus.busy), 128'(0));

        // Illegal length from IDLE: pulse only, nothing starts.
        bus.key_len = 2'b11;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("idle lenerr pulse", 128'(bus.len_err), 128'(1));
        check("idle lenerr busy", 128'(bus.busy), 128'(0));
        check("idle lenerr kv", 128'(bus.keys_valid), 128'(0));
        @(negedge clk);

        run_expand(2'b00, k128p, -1, "restart");
        read_rk(10, rk);
        check("restart rk10", rk, RK10_128);
        read_rk(0, rk);
        check("restart rk0", rk, K128);

        // Random keys of every length against the reference model.
        for (int r = 0; r < 6; r++) begin
            rlen = 2'(r % 3);
            rkey = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
            model_expand(rlen, rkey);
            run_expand(rlen, rkey, -1, $sformatf("rand%0d", r));
            for (int t = 0; t <= cur_nr; t++) begin
                read_rk(t, rk);
                check($sformatf("rand%0d rk%0d", r, t), rk,
                      {w_m[4*t], w_m[4*t+1], w_m[4*t+2], w_m[4*t+3]});
            end
            read_rk(cur_nr + 1, rk);
            check($sformatf("rand%0d beyond_nr", r), rk, 128'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound so a stuck DUT still ends the run.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected run completion");
        $fatal(1, "watchdog expired");
    end

endmodule
